// File: rtl/fixed_mac_pkg.sv
// ---------------------------------------------------------------------------
// fixed_mac_pkg
// Shared types and width helpers for the fixed-point multiply-accumulate
// front end (fixed_mac_acc) and its adder (sat_add).
//   - mac_state_e : frame sequencing states ACCUM / DRAIN / HOLD
//   - frac_prod_w / prod_w / acc_w : derived widths WFP, PW, AW
//   - SAT_MAX / SAT_MIN : clamp limits for the default accumulator width
// Optional feature macro used by the consumers: FIXED_MAC_SATURATE_EN.
// ---------------------------------------------------------------------------
package fixed_mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_e;

    // Fractional bits of a product: WFP = WF1 + WF2
    function automatic int frac_prod_w(input int wf1, input int wf2);
        return wf1 + wf2;
    endfunction

    // Full-precision product width: PW = WI1 + WI2 + WFP
    function automatic int prod_w(input int wi1, input int wf1,
                                  input int wi2, input int wf2);
        return wi1 + wi2 + frac_prod_w(wf1, wf2);
    endfunction

    // Accumulator width: AW = WIA + WFP
    function automatic int acc_w(input int wia, input int wf1, input int wf2);
        return wia + frac_prod_w(wf1, wf2);
    endfunction

    localparam int DEF_AW = acc_w(12, 11, 11);

    // Most positive / most negative two's-complement values of the default accumulator
    localparam logic [DEF_AW-1:0] SAT_MAX = {1'b0, {(DEF_AW-1){1'b1}}};
    localparam logic [DEF_AW-1:0] SAT_MIN = {1'b1, {(DEF_AW-1){1'b0}}};

endpackage

// File: rtl/fixed_mac_acc_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// W-bit signed adder with overflow flag. Overflow is raised when both
// operands share a sign and the raw sum's sign differs.
// With FIXED_MAC_SATURATE_EN defined the sum clamps to the signed max/min in
// the direction of the overflow; otherwise it wraps (two's complement).
// Ports:
//   a_in    [W-1:0] in  : accumulator operand (signed)
//   b_in    [W-1:0] in  : addend (signed)
//   sum_out [W-1:0] out : wrapped or clamped sum
//   ovf_out         out : signed overflow of this add
// ---------------------------------------------------------------------------
module sat_add #(
    parameter int W = 34
) (
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] sum_out,
    output logic         ovf_out
);

    logic [W-1:0] raw_s;
    logic         ovf_s;

    // Raw wrapping sum and signed-overflow detection
    always_comb begin
        raw_s = a_in + b_in;
        ovf_s = (a_in[W-1] == b_in[W-1]) && (raw_s[W-1] != a_in[W-1]);
    end

`ifdef FIXED_MAC_SATURATE_EN
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    // Clamp toward the operands' common sign on overflow
    always_comb begin
        if (ovf_s) begin
            sum_out = a_in[W-1] ? MIN_V : MAX_V;
        end else begin
            sum_out = raw_s;
        end
    end
`else
    // Wrapping accumulation: pass the raw sum through
    always_comb begin
        sum_out = raw_s;
    end
`endif

    assign ovf_out = ovf_s;

endmodule

// File: rtl/fixed_mac_acc.sv
// ---------------------------------------------------------------------------
// fixed_mac_acc
// Streaming signed fixed-point multiply-accumulate. Each accepted beat
// registers the exact product a*b (stage 1); stage 2 sign-extends it and
// adds it into a Q(WIA.WFP) accumulator. A frame ends on in_last; the sum,
// the beat count and a sticky overflow flag are then held on a valid/ready
// output until consumed, which also clears them for the next frame.
// Optional feature: FIXED_MAC_SATURATE_EN (clamping instead of wrapping).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : operand beat handshake, in_last marks frame end
//   a [WI1+WF1], b [WI2+WF2] : signed operands
//   out_valid/out_ready   : result handshake
//   acc_out [AW]          : frame sum, beat_cnt [CNT_W] : beats, overflow
// ---------------------------------------------------------------------------
module fixed_mac_acc
    import fixed_mac_pkg::*;
#(
    parameter int WI1   = 5,
    parameter int WF1   = 11,
    parameter int WI2   = 5,
    parameter int WF2   = 11,
    parameter int WIA   = 12,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [WI1+WF1-1:0]       a,
    input  logic [WI2+WF2-1:0]       b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIA+WF1+WF2-1:0]   acc_out,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic                     overflow
);

    localparam int PW = prod_w(WI1, WF1, WI2, WF2);
    localparam int AW = acc_w(WIA, WF1, WF2);

    mac_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             prod_vld_q, prod_vld_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept_s;
    logic             release_s;
    logic [PW-1:0]    a_ext_s, b_ext_s;
    logic [AW-1:0]    prod_ext_s;
    logic [AW-1:0]    sum_s;
    logic             add_ovf_s;

    assign accept_s  = in_valid && in_ready_q;
    assign release_s = out_valid_q && out_ready;

    // Frame sequencing: next state and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                out_valid_d = 1'b0;
                if (accept_s && in_last) begin
                    state_d    = DRAIN;
                    in_ready_d = 1'b0;
                end else begin
                    state_d    = ACCUM;
                    in_ready_d = 1'b1;
                end
            end
            DRAIN: begin
                in_ready_d = 1'b0;
                // Result is ready once the last product has left stage 1
                if (!prod_vld_q) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (release_s) begin
                    state_d     = ACCUM;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = HOLD;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Stage 1 product and stage 2 accumulate/count/overflow next values
    always_comb begin
        // Low PW bits of the product of sign-extended operands are the exact signed product
        a_ext_s    = PW'($signed(a));
        b_ext_s    = PW'($signed(b));
        prod_vld_d = accept_s;
        if (accept_s) begin
            prod_d = a_ext_s * b_ext_s;
        end else begin
            prod_d = prod_q;
        end

        prod_ext_s = AW'($signed(prod_q));
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (release_s) begin
            acc_d = {AW{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
        end else if (prod_vld_q) begin
            acc_d = sum_s;
            ovf_d = ovf_q | add_ovf_s;
            if (cnt_q == {CNT_W{1'b1}}) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    sat_add #(
        .W (AW)
    ) u_sat_add (
        .a_in    (acc_q),
        .b_in    (prod_ext_s),
        .sum_out (sum_s),
        .ovf_out (add_ovf_s)
    );

    // FSM state and handshake output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath registers: product pipeline, accumulator, count, overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q     <= {PW{1'b0}};
            prod_vld_q <= 1'b0;
            acc_q      <= {AW{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign beat_cnt  = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fixed_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_fixed_mac_acc
// Directed and randomized frames for fixed_mac_acc, checked against an
// arithmetic reference of the frame sum (integer products, range-checked
// accumulation with wrap or clamp depending on FIXED_MAC_SATURATE_EN).
// ---------------------------------------------------------------------------
module tb_fixed_mac_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] acc_out;
    logic [7:0]  beat_cnt;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    int stalls;

    logic [15:0] av[$];
    logic [15:0] bv[$];

    logic [33:0] e_acc;
    logic [7:0]  e_cnt;
    logic        e_ovf;

    fixed_mac_acc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .beat_cnt  (beat_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact products summed as integers; leaving the Q12.22 range wraps or clamps
    function automatic void model_frame(output logic [33:0] r_acc, output logic [7:0] r_cnt,
                                        output logic r_ovf);
        longint s;
        longint p;
        longint hi;
        longint lo;
        hi    = 64'sh1_FFFF_FFFF;
        lo    = -64'sh2_0000_0000;
        s     = 64'sd0;
        r_ovf = 1'b0;
        for (int i = 0; i < av.size(); i++) begin
            p = longint'($signed(av[i])) * longint'($signed(bv[i]));
            s = s + p;
            if (s > hi || s < lo) begin
                r_ovf = 1'b1;
`ifdef FIXED_MAC_SATURATE_EN
                s = (s > hi) ? hi : lo;
`else
                s = (s > hi) ? (s - 64'sh4_0000_0000) : (s + 64'sh4_0000_0000);
`endif
            end
        end
        r_acc = s[33:0];
        r_cnt = (av.size() > 255) ? 8'hFF : 8'(av.size());
    endfunction

    // Present every beat of av/bv; starts and ends on a falling edge
    task automatic send_frame(input bit do_last, input bit gaps);
        int waited;
        stalls = 0;
        for (int i = 0; i < av.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            a        = av[i];
            b        = bv[i];
            in_last  = do_last && (i == av.size() - 1);
            waited   = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
                stalls++;
            end
            if (waited >= 50) begin
                chk("in_ready_timeout", 64'(in_ready), 64'd1);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Latency, result, optional backpressure hold, then consume and check the clear
    task automatic finish_frame(input string tag, input logic [33:0] x_acc, input logic [7:0] x_cnt,
                                input logic x_ovf, input int hold_cyc, input bit hold_valid);
        chk({tag, "_ovalid_t0"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_ovalid_t1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_ovalid_t2"}, 64'(out_valid), 64'd1);
        chk({tag, "_acc"}, 64'(acc_out), 64'(x_acc));
        chk({tag, "_cnt"}, 64'(beat_cnt), 64'(x_cnt));
        chk({tag, "_ovf"}, 64'(overflow), 64'(x_ovf));
        for (int k = 0; k < hold_cyc; k++) begin
            in_valid = hold_valid;
            a        = 16'(($urandom));
            b        = 16'(($urandom));
            @(negedge clk);
            chk({tag, "_hold_iready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_ovalid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_acc"}, 64'(acc_out), 64'(x_acc));
            chk({tag, "_hold_cnt"}, 64'(beat_cnt), 64'(x_cnt));
            chk({tag, "_hold_ovf"}, 64'(overflow), 64'(x_ovf));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_ovalid"}, 64'(out_valid), 64'd0);
        chk({tag, "_rel_acc"}, 64'(acc_out), 64'd0);
        chk({tag, "_rel_cnt"}, 64'(beat_cnt), 64'd0);
        chk({tag, "_rel_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_rel_iready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic fill(input int n, input logic [15:0] va, input logic [15:0] vb);
        av.delete();
        bv.delete();
        for (int i = 0; i < n; i++) begin
            av.push_back(va);
            bv.push_back(vb);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_iready", 64'(in_ready), 64'd0);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_iready", 64'(in_ready), 64'd1);

        // 4 x (1.5 * 2.0) = 12.0
        fill(4, 16'h0C00, 16'h1000);
        send_frame(1'b1, 1'b0);
        chk("f4_stalls", 64'(stalls), 64'd0);
        finish_frame("f4", 34'h003000000, 8'd4, 1'b0, 0, 1'b0);

        // Single beat -1.0 * 1.0
        fill(1, 16'hF800, 16'h0800);
        send_frame(1'b1, 1'b0);
        finish_frame("f1neg", 34'h3FFC00000, 8'd1, 1'b0, 0, 1'b0);

        // 8 x (-16 * -16) overflows; held 5 cycles under backpressure with in_valid high
        fill(8, 16'h8000, 16'h8000);
        send_frame(1'b1, 1'b0);
`ifdef FIXED_MAC_SATURATE_EN
        finish_frame("f8ovf", 34'h1FFFFFFFF, 8'd8, 1'b1, 5, 1'b1);
`else
        finish_frame("f8ovf", 34'h200000000, 8'd8, 1'b1, 5, 1'b1);
`endif

        // Next frame starts from zero: 1.0 * 1.0
        fill(1, 16'h0800, 16'h0800);
        send_frame(1'b1, 1'b0);
        finish_frame("after_ovf", 34'h000400000, 8'd1, 1'b0, 0, 1'b0);

        // Reset after 2 beats of a 4-beat frame
        fill(2, 16'h0C00, 16'h1000);
        send_frame(1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_iready", 64'(in_ready), 64'd0);
        chk("midrst_ovalid", 64'(out_valid), 64'd0);
        chk("midrst_acc", 64'(acc_out), 64'd0);
        chk("midrst_cnt", 64'(beat_cnt), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        fill(1, 16'h0800, 16'h0800);
        send_frame(1'b1, 1'b0);
        finish_frame("postrst", 34'h000400000, 8'd1, 1'b0, 0, 1'b0);

        // Alternating +3.0 / -3.0, six pairs, back-to-back
        av.delete();
        bv.delete();
        for (int i = 0; i < 6; i++) begin
            av.push_back(16'h0C00);
            bv.push_back(16'h1000);
            av.push_back(16'hF400);
            bv.push_back(16'h1000);
        end
        send_frame(1'b1, 1'b0);
        chk("alt_stalls", 64'(stalls), 64'd0);
        finish_frame("alt", 34'h000000000, 8'd12, 1'b0, 0, 1'b0);

        // Beat counter saturation: 260-beat frame of random operands
        av.delete();
        bv.delete();
        for (int i = 0; i < 260; i++) begin
            av.push_back(16'($urandom));
            bv.push_back(16'($urandom));
        end
        model_frame(e_acc, e_cnt, e_ovf);
        send_frame(1'b1, 1'b0);
        finish_frame("cntsat", e_acc, e_cnt, e_ovf, 0, 1'b0);

        // Random frames with idle gaps and random result backpressure
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, 16);
            av.delete();
            bv.delete();
            for (int i = 0; i < n; i++) begin
                av.push_back(16'($urandom));
                bv.push_back(16'($urandom));
            end
            model_frame(e_acc, e_cnt, e_ovf);
            send_frame(1'b1, 1'b1);
            finish_frame($sformatf("rnd%0d", f), e_acc, e_cnt, e_ovf,
                         $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fixed_mac_acc.md
Name: fixed_mac_acc

Overview:
- Streaming fixed-point multiply-accumulate front end for the Fixed_mul_accumulation datapath.
- Accepts signed Q(WI1.WF1) × Q(WI2.WF2) operand pairs over a valid/ready stream and sums one frame of products, delimited by in_last, into a wide accumulator.
- Presents the full-precision sum, beat count and overflow on a valid/ready output.
- This is the producer side; the downstream format-resize stage narrows acc_out to the user output format.

Parameters:
- WI1, 5: integer bits of operand a, sign included
- WF1, 11: fractional bits of operand a
- WI2, 5: integer bits of operand b, sign included
- WF2, 11: fractional bits of operand b
- WIA, 12: integer bits of accumulator; must be ≥ WI1+WI2
- CNT_W, 8: width of beat counter; frames up to 2^CNT_W-1 beats
- Derived: WFP = WF1+WF2; PW = WI1+WI2+WFP; AW = WIA+WFP

Ports:
- clk, input, 1: clock
- reset, input, 1: synchronous, active-high reset
- in_valid, input, 1: operand beat valid
- in_ready, output, 1: block can accept a beat
- in_last, input, 1: beat is last of frame
- a, input, WI1+WF1: signed operand a
- b, input, WI2+WF2: signed operand b
- out_valid, output, 1: result valid
- out_ready, input, 1: downstream accepts result
- acc_out, output, AW: signed Q(WIA.WFP) frame sum
- beat_cnt, output, CNT_W: number of beats in the frame
- overflow, output, 1: sticky accumulation overflow for the frame

Behaviour:
- One clock domain (clk). Synchronous active-high reset. All state is cleared on the reset edge:
  - in_ready=0 during reset, 1 on the first cycle after
  - out_valid=0, acc_out=0, beat_cnt=0, overflow=0
- Beat accepted when in_valid && in_ready.
- Stage 1: the accepted beat registers the product p = a*b, signed, full PW bits in Q(WI1+WI2).WFP. No rounding and no truncation.
- Stage 2: p is sign-extended to AW and added to the accumulator. beat_cnt increments; it saturates at all-ones.
- Overflow: an add overflows when both operands have equal sign and the result sign differs. overflow is sticky until the frame result is consumed. In the default build the accumulator wraps (two's complement).
- FSM:
  - ACCUM: in_ready=1. Accepted beat with in_last → DRAIN.
  - DRAIN: in_ready=0. The final product is added; the following cycle → HOLD.
  - HOLD: out_valid=1, in_ready=0; outputs stable. out_valid && out_ready → ACCUM, with accumulator, beat_cnt and overflow cleared in the same cycle.
- Latency: last beat accepted at edge t. out_valid is high after edge t+2. Earliest next accepted beat is at the edge where out_ready is sampled high.
- Back-to-back beats: one beat per cycle is sustained in ACCUM.
- A single-beat frame (in_last on the first beat) gives acc_out = that product and beat_cnt = 1.
- Reset asserted mid-frame or in HOLD discards the partial sum. No output is produced for that frame.
- Held outputs: acc_out, beat_cnt and overflow stay unchanged while out_valid=1 && out_ready=0.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: FIXED_MAC_SATURATE_EN.
- Defined: on overflow the accumulator clamps.
  - Positive overflow gives max = 2^(AW-1)-1.
  - Negative overflow gives min = -2^(AW-1).
  - Further adds in the same direction keep the clamped value. overflow is still set.
- Undefined: two's-complement wrap, as specified above.

Decomposition:
- Package fixed_mac_pkg:
  - State enum {ACCUM, DRAIN, HOLD}
  - Width helper functions for WFP/PW/AW
  - Localparams for saturation max/min
- Sub-module sat_add: AW-bit signed adder producing sum plus overflow. Saturation logic sits behind FIXED_MAC_SATURATE_EN. It is instantiated once in stage 2.

Test Plan:
- Frame of 4 beats, a=0x0C00 (1.5), b=0x1000 (2.0), in_last on beat 4 → out_valid 2 cycles after the last beat; acc_out=0x003000000 (12.0); beat_cnt=4; overflow=0.
- Single beat, a=0xF800 (-1.0), b=0x0800 (1.0) with in_last → acc_out=all-ones-shifted −1.0 = 0x3FFC00000; beat_cnt=1.
- 8 beats of a=b=0x8000 (-16) in the default build → acc_out=0x200000000 (wrapped, -2048.0); overflow=1. With FIXED_MAC_SATURATE_EN → acc_out=0x1FFFFFFFF; overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 → in_ready=0 throughout; outputs stable. Release out_ready → the next frame starts from 0 and overflow is cleared.
- Reset asserted after 2 beats of a 4-beat frame → all outputs 0 on the next cycle. A following 1-beat frame of 1.0×1.0 → acc_out=0x000400000.
- Continuous in_valid with alternating-sign products (+3.0, -3.0)×6 → one beat per cycle accepted; final acc_out=0; overflow=0.
